prog_inst_mem: RTL and testbench

Parametrised, runtime-loadable instruction memory for the pipelined MIPS core's fetch stage. Byte-addressable, big-endian storage of `DEPTH_BYTES` bytes, filled through a byte-serial loader port instead of fixed initial contents. Instruction fetch is registered: one-cycle latency with a valid flag. Sits between the PC register and the IF/ID pipeline register; the loader port is driven by the testbench or a boot controller.

---
 rtl/prog_inst_mem_if.sv | 29 ++
 rtl/prog_inst_mem.sv | 137 +++++++++++++
 tb/tb_prog_inst_mem.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_inst_mem_if.sv
// prog_inst_mem_if: fetch and loader signal bundle for prog_inst_mem.
//   master : PC/fetch requester and program loader (testbench or boot controller)
//   slave  : the instruction memory itself
// Fetch  : fetch_req, pc -> inst_code, inst_valid, fault
// Loader : ld_start, ld_valid, ld_byte, ld_last -> ld_ready, ld_done, busy
interface prog_inst_mem_if;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] inst_code;
  logic        inst_valid;
  logic        fault;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic        busy;

  modport master (
    output fetch_req, pc, ld_start, ld_valid, ld_byte, ld_last,
    input  inst_code, inst_valid, fault, ld_ready, ld_done, busy
  );

  modport slave (
    input  fetch_req, pc, ld_start, ld_valid, ld_byte, ld_last,
    output inst_code, inst_valid, fault, ld_ready, ld_done, busy
  );
endinterface

// File: rtl/prog_inst_mem.sv
// prog_inst_mem: runtime-loadable, byte-addressable, big-endian instruction
// memory for the fetch stage. Bytes are streamed in through the loader port;
// fetches return a 32-bit word one cycle after the request.
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-low reset (also clears the memory array)
//   bus    : prog_inst_mem_if.slave (fetch and loader signals)
// Parameters:
//   DEPTH_BYTES : memory size in bytes (multiple of 4, >= 8)
//   NOP_WORD    : word returned on a faulted fetch
// Optional feature:
//   IMEM_BOUNDS_CHECK_EN : when defined, misaligned or out-of-range fetches
//   return NOP_WORD with fault=1; otherwise byte addresses wrap modulo
//   DEPTH_BYTES and fault stays 0.
module prog_inst_mem #(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  prog_inst_mem_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH_BYTES);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH_BYTES - 1);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_RUN
  } state_t;

  state_t      state;
  logic [PW-1:0] ld_ptr;
  logic [7:0]  mem [DEPTH_BYTES];

  logic [31:0] inst_code_q;
  logic        inst_valid_q;
  logic        fault_q;
  logic        ld_done_q;

  logic [31:0] fetch_word;
  logic        fetch_fault;

`ifdef IMEM_BOUNDS_CHECK_EN
  // Only reached for aligned, in-range pc, so pc+off never leaves the array.
  function automatic logic [PW-1:0] byte_index(input logic [31:0] addr,
                                               input int unsigned off);
    return PW'(addr + off);
  endfunction
`else
  // Reduce pc first so the +off step needs at most one wrap subtraction.
  function automatic logic [PW-1:0] byte_index(input logic [31:0] addr,
                                               input int unsigned off);
    logic [31:0] idx;
    idx = (addr % 32'(DEPTH_BYTES)) + off;
    if (idx >= 32'(DEPTH_BYTES)) idx = idx - 32'(DEPTH_BYTES);
    return PW'(idx);
  endfunction
`endif

  always_comb begin
    fetch_word  = NOP_WORD;
    fetch_fault = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    if (bus.pc[1:0] != 2'b00 || bus.pc > 32'(DEPTH_BYTES - 4)) begin
      fetch_fault = 1'b1;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        fetch_word[8*(3-i) +: 8] = mem[byte_index(bus.pc, i)];
      end
    end
`else
    for (int unsigned i = 0; i < 4; i++) begin
      fetch_word[8*(3-i) +: 8] = mem[byte_index(bus.pc, i)];
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_EMPTY;
      ld_ptr       <= '0;
      inst_code_q  <= '0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      ld_done_q    <= 1'b0;
      mem          <= '{default: '0};
    end else begin
      ld_done_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (bus.ld_start) begin
            state  <= S_LOAD;
            ld_ptr <= '0;
          end
        end
        S_LOAD: begin
          // Restart has priority; a byte offered in the same cycle is dropped.
          if (bus.ld_start) begin
            ld_ptr <= '0;
          end else if (bus.ld_valid) begin
            mem[ld_ptr] <= bus.ld_byte;
            ld_ptr      <= ld_ptr + PW'(1);
            if (bus.ld_last || ld_ptr == LAST_PTR) begin
              state     <= S_RUN;
              ld_done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // A load request pre-empts a same-cycle fetch; inst_code holds.
          if (bus.ld_start) begin
            state  <= S_LOAD;
            ld_ptr <= '0;
          end else if (bus.fetch_req) begin
            inst_valid_q <= 1'b1;
            inst_code_q  <= fetch_word;
            fault_q      <= fetch_fault;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign bus.inst_code  = inst_code_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fault      = fault_q;
  assign bus.ld_done    = ld_done_q;
  assign bus.ld_ready   = (state == S_LOAD);
  assign bus.busy       = (state == S_LOAD);

endmodule

// File: tb/tb_prog_inst_mem.sv
// Testbench for prog_inst_mem: directed loads and fetches. Fetch expectations
// are queued at issue time and checked by an independent monitor one cycle
// after each request; loader handshake outputs are checked inline.
module tb_prog_inst_mem;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk;
  logic reset;

  prog_inst_mem_if bus ();

  prog_inst_mem #(
    .DEPTH_BYTES (64),
    .NOP_WORD    (NOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] code;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_code;
  int          errors;
  int          checks;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inst_code holds across non-serviced fetches, so track the last valid word.
  task automatic push(input string name, input logic valid, input logic [31:0] code,
                      input logic fault);
    exp_t e;
    if (valid) model_code = code;
    e.name  = name;
    e.valid = valid;
    e.code  = model_code;
    e.fault = fault;
    sb.push_back(e);
  endtask

  task automatic issue(input string name, input logic [31:0] addr, input logic valid,
                       input logic [31:0] code, input logic fault);
    @(negedge clk);
    bus.fetch_req = 1'b1;
    bus.pc        = addr;
    push(name, valid, code, fault);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.fetch_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input bool_chk_ready);
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b0;
    #1;
    if (bool_chk_ready) check("ld_ready_at_start", {31'b0, bus.ld_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    check("ready_after_start", {31'b0, bus.ld_ready}, 32'd1);
    @(negedge clk);
    bus.ld_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic exp_done);
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = b;
    bus.ld_last  = last;
    @(posedge clk);
    #1;
    check("ld_done", {31'b0, bus.ld_done}, {31'b0, exp_done});
  endtask

  task automatic end_load();
    @(negedge clk);
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    @(posedge clk);
    #1;
    check("ld_done_drop", {31'b0, bus.ld_done}, 32'd0);
    check("busy_in_run", {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_inst_code"},  bus.inst_code, 32'd0);
    check({tag, "_inst_valid"}, {31'b0, bus.inst_valid}, 32'd0);
    check({tag, "_fault"},      {31'b0, bus.fault}, 32'd0);
    check({tag, "_ld_ready"},   {31'b0, bus.ld_ready}, 32'd0);
    check({tag, "_ld_done"},    {31'b0, bus.ld_done}, 32'd0);
    check({tag, "_busy"},       {31'b0, bus.busy}, 32'd0);
  endtask

  // Monitor: a request sampled at a rising edge is answered just after the next one.
  initial begin
    logic req;
    exp_t e;
    req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (req) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow: got response with empty queue");
        end else begin
          e = sb.pop_front();
          check({e.name, "_valid"}, {31'b0, bus.inst_valid}, {31'b0, e.valid});
          check({e.name, "_code"},  bus.inst_code, e.code);
          check({e.name, "_fault"}, {31'b0, bus.fault}, {31'b0, e.fault});
        end
      end else if (bus.inst_valid !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got inst_valid=%b expected 0", bus.inst_valid);
      end
      // Request for the next edge is stable from the preceding falling edge.
      @(negedge clk);
      #1;
      req = bus.fetch_req && reset;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] prog1 [8];

  initial begin
    errors       = 0;
    checks       = 0;
    model_code   = '0;
    reset        = 1'b0;
    bus.fetch_req = 1'b0;
    bus.pc       = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_byte  = '0;
    bus.ld_last  = 1'b0;
    prog1 = '{8'h8d, 8'h61, 8'h00, 8'h0c, 8'h3d, 8'h02, 8'h00, 8'h08};

    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Fetch in EMPTY is not serviced.
    issue("empty_fetch", 32'd0, 1'b0, 32'd0, 1'b0);
    idle();

    // Load first program.
    start_load(1'b1);
    for (int i = 0; i < 8; i++) send_byte(prog1[i], (i == 7), (i == 7));
    end_load();

    // Back-to-back fetches plus alignment/range boundaries.
    issue("pc0", 32'd0, 1'b1, 32'h8d61000c, 1'b0);
    issue("pc2", 32'd2, 1'b1, BOUNDS ? NOP : 32'h000c3d02, BOUNDS);
    issue("pc62", 32'd62, 1'b1, BOUNDS ? NOP : 32'h00008d61, BOUNDS);
    issue("pc64", 32'd64, 1'b1, BOUNDS ? NOP : 32'h8d61000c, BOUNDS);
    issue("pc60", 32'd60, 1'b1, 32'h00000000, 1'b0);
    issue("pc4", 32'd4, 1'b1, 32'h3d020008, 1'b0);
    idle();

    // Reload during RUN: load wins over a same-cycle fetch.
    @(negedge clk);
    bus.ld_start  = 1'b1;
    bus.fetch_req = 1'b1;
    bus.pc        = 32'd0;
    push("reload_fetch", 1'b0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    check("reload_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.ld_start  = 1'b0;
    bus.fetch_req = 1'b0;
    send_byte(8'ha0, 1'b0, 1'b0);
    send_byte(8'hb1, 1'b0, 1'b0);
    send_byte(8'hc2, 1'b0, 1'b0);
    send_byte(8'hd3, 1'b1, 1'b1);
    end_load();
    issue("reload_pc0", 32'd0, 1'b1, 32'ha0b1c2d3, 1'b0);
    issue("reload_pc4", 32'd4, 1'b1, 32'h3d020008, 1'b0);
    idle();

    // Restart during LOAD after 3 bytes; the byte offered with the restart is dropped.
    start_load(1'b1);
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    @(negedge clk);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hee;
    bus.ld_last  = 1'b1;
    @(posedge clk);
    #1;
    check("restart_no_done", {31'b0, bus.ld_done}, 32'd0);
    check("restart_busy", {31'b0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    send_byte(8'h55, 1'b1, 1'b1);
    end_load();
    issue("restart_pc0", 32'd0, 1'b1, 32'h552233d3, 1'b0);
    idle();

    // Full-depth load, no ld_last: completes on the final address.
    start_load(1'b1);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0, (i == 63));
    end_load();

    // ld_valid outside LOAD must not write.
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_byte  = 8'hff;
    @(negedge clk);
    bus.ld_valid = 1'b0;

    issue("full_pc60", 32'd60, 1'b1, 32'h3c3d3e3f, 1'b0);
    issue("full_pc0", 32'd0, 1'b1, 32'h00010203, 1'b0);
    idle();

    // Reset in the middle of a load.
    start_load(1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'hf0 + 8'(i), 1'b0, 1'b0);
    @(negedge clk);
    bus.ld_valid = 1'b0;
    reset        = 1'b0;
    model_code   = '0;
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    reset = 1'b1;
    issue("post_reset_fetch", 32'd0, 1'b0, 32'd0, 1'b0);
    idle();
    start_load(1'b1);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b1, 1'b1);
    end_load();
    issue("cleared_pc4", 32'd4, 1'b1, 32'h00000000, 1'b0);
    issue("fresh_pc0", 32'd0, 1'b1, 32'h01020304, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
